// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt controller control unit.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT = 3'd0,
    ST_ICW2   = 3'd1,
    ST_ICW3   = 3'd2,
    ST_ICW4   = 3'd3,
    ST_READY  = 3'd4
  } init_st_e;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK1     = 2'd1,
    ACK2     = 2'd2
  } ack_st_e;

  // ICW1 / ICW4 bit positions
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;
  localparam int ICW4_AEOI = 1;

  // OCW2 command codes (din[7:5])
  localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS  = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP  = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI = 3'b110;

  function automatic bit num_irq_legal(input int n);
    return (n == 2) || (n == 4) || (n == 8);
  endfunction

endpackage

// File: rtl/pic_control_unit_resolver.sv
// Rotating priority encoder: level lowest+1 is highest priority, lowest is last.
module pic_priority_resolver #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    lowest,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from lowest priority up so the highest-priority hit is written last.
  // NUM_IRQ is a power of two, so the ID_W-bit add wraps modulo NUM_IRQ.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_IRQ; i >= 1; i--) begin
      if (req[lowest + ID_W'(i)]) begin
        valid = 1'b1;
        id    = lowest + ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/pic_control_unit.sv
// Interrupt controller control unit: init sequence, OCW decode, IRR/ISR/IMR,
// nested rotating priority and the two-pulse INTA handshake.
module pic_control_unit
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_n,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta_n,
  output logic               intr,
  output logic [7:0]         vec_out,
  output logic               vec_oe,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr,
  output logic               init_done
);

  if (!num_irq_legal(NUM_IRQ)) begin : g_bad_num_irq
    $error("pic_control_unit: NUM_IRQ must be 2, 4 or 8");
  end

  logic               wr_n_q, inta_n_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic [7:0]         icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d;
  logic               aeoi_q, aeoi_d;
  init_st_e           init_q, init_d;
  ack_st_e            ack_q, ack_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irr_clr;
  logic [ID_W-1:0]    lowest_q, lowest_d, id_q, id_d, lvl;
  logic               spur_q, spur_d, intr_q, intr_d, vec_oe_q, vec_oe_d;
  logic [7:0]         vec_out_q, vec_out_d;

  logic               wr_ev, icw1_ev, ocw_ev, inta_fall, inta_rise;
  logic               cand_vld, isr_vld, pend;
  logic [ID_W-1:0]    cand_id, isr_id, cand_rank, isr_rank;
  logic               unused_bits;

  // ICW3 is kept for software visibility only; these bits steer nothing here.
  assign unused_bits = ^{icw3_q, icw1_q[7:4], icw1_q[2], icw2_q[ID_W-1:0]};

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_irr_res (
    .req(irr_q & ~imr_q), .lowest(lowest_q), .valid(cand_vld), .id(cand_id)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
    .req(isr_q), .lowest(lowest_q), .valid(isr_vld), .id(isr_id)
  );

  // Rank 0 is the highest priority (lowest+1); strict compare keeps a level
  // already in service from re-interrupting itself.
  assign cand_rank = cand_id - lowest_q - ID_W'(1);
  assign isr_rank  = isr_id  - lowest_q - ID_W'(1);
  assign pend      = cand_vld && (!isr_vld || (cand_rank < isr_rank));

  assign wr_ev     = wr_n_q & ~wr_n;
  assign icw1_ev   = wr_ev & ~a0 & din[ICW1_SEL];
  assign ocw_ev    = wr_ev & ~icw1_ev & (init_q == ST_READY);
  assign inta_fall = inta_n_q & ~inta_n;
  assign inta_rise = ~inta_n_q & inta_n;
  assign lvl       = din[ID_W-1:0];

  // Next-state: init sequence, OCWs, ack handshake, then ICW1 override last.
  always_comb begin
    icw1_d    = icw1_q;
    icw2_d    = icw2_q;
    icw3_d    = icw3_q;
    aeoi_d    = aeoi_q;
    init_d    = init_q;
    ack_d     = ack_q;
    isr_d     = isr_q;
    imr_d     = imr_q;
    irr_clr   = '0;
    lowest_d  = lowest_q;
    id_d      = id_q;
    spur_d    = spur_q;
    vec_oe_d  = vec_oe_q;
    vec_out_d = vec_out_q;

    if (wr_ev && a0) begin
      unique case (init_q)
        ST_ICW2: begin
          icw2_d = din;
          if (!icw1_q[ICW1_SNGL])    init_d = ST_ICW3;
          else if (icw1_q[ICW1_IC4]) init_d = ST_ICW4;
          else                       init_d = ST_READY;
        end
        ST_ICW3: begin
          icw3_d = din;
          init_d = icw1_q[ICW1_IC4] ? ST_ICW4 : ST_READY;
        end
        ST_ICW4: begin
          aeoi_d = din[ICW4_AEOI];
          init_d = ST_READY;
        end
        default: ;
      endcase
    end

    // OCW1 / OCW2; EOI picks from the registered ISR, ahead of any ack set.
    if (ocw_ev && a0) begin
      imr_d = din[NUM_IRQ-1:0];
    end else if (ocw_ev && din[4:3] == 2'b00) begin
      unique case (din[7:5])
        OCW2_NS_EOI: if (isr_vld) isr_d[isr_id] = 1'b0;
        OCW2_SP_EOI: isr_d[lvl] = 1'b0;
        OCW2_ROT_NS: if (isr_vld) begin
          isr_d[isr_id] = 1'b0;
          lowest_d      = isr_id;
        end
        OCW2_ROT_SP: begin
          isr_d[lvl] = 1'b0;
          lowest_d   = lvl;
        end
        OCW2_SET_PRI: lowest_d = lvl;
        default: ;
      endcase
    end

    unique case (ack_q)
      ACK_IDLE: if (inta_fall) begin
        ack_d  = ACK1;
        spur_d = ~cand_vld;
        if (cand_vld) begin
          id_d           = cand_id;
          isr_d[cand_id] = 1'b1;
          irr_clr[cand_id] = 1'b1;
        end else begin
          id_d = ID_W'(NUM_IRQ - 1);
        end
      end
      ACK1: if (inta_fall) begin
        ack_d     = ACK2;
        vec_out_d = {icw2_q[7:ID_W], id_q};
        vec_oe_d  = 1'b1;
      end
      ACK2: if (inta_rise) begin
        ack_d     = ACK_IDLE;
        vec_oe_d  = 1'b0;
        vec_out_d = '0;
        if (aeoi_q && !spur_q) isr_d[id_q] = 1'b0;
      end
      default: ack_d = ACK_IDLE;
    endcase

    if (icw1_ev) begin
      icw1_d    = din;
      init_d    = ST_ICW2;
      imr_d     = '0;
      isr_d     = '0;
      irr_clr   = '0;
      ack_d     = ACK_IDLE;
      spur_d    = 1'b0;
      vec_oe_d  = 1'b0;
      vec_out_d = '0;
    end

    // Edge mode: a fresh rising edge beats the ack clear on the same bit.
    if (icw1_q[ICW1_LTIM]) irr_d = irq;
    else                   irr_d = (irr_q & ~irr_clr) | (irq & ~irq_q);

    intr_d = pend && (init_q == ST_READY) && (ack_q == ACK_IDLE)
             && !inta_fall && !icw1_ev;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_n_q    <= 1'b0;
      inta_n_q  <= 1'b0;
      irq_q     <= '0;
      icw1_q    <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      aeoi_q    <= 1'b0;
      init_q    <= ST_UNINIT;
      ack_q     <= ACK_IDLE;
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= '0;
      lowest_q  <= ID_W'(NUM_IRQ - 1);
      id_q      <= '0;
      spur_q    <= 1'b0;
      intr_q    <= 1'b0;
      vec_oe_q  <= 1'b0;
      vec_out_q <= '0;
    end else begin
      wr_n_q    <= wr_n;
      inta_n_q  <= inta_n;
      irq_q     <= irq;
      icw1_q    <= icw1_d;
      icw2_q    <= icw2_d;
      icw3_q    <= icw3_d;
      aeoi_q    <= aeoi_d;
      init_q    <= init_d;
      ack_q     <= ack_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      lowest_q  <= lowest_d;
      id_q      <= id_d;
      spur_q    <= spur_d;
      intr_q    <= intr_d;
      vec_oe_q  <= vec_oe_d;
      vec_out_q <= vec_out_d;
    end
  end

  assign intr      = intr_q;
  assign vec_out   = vec_out_q;
  assign vec_oe    = vec_oe_q;
  assign irr       = irr_q;
  assign isr       = isr_q;
  assign imr       = imr_q;
  assign init_done = (init_q == ST_READY);

endmodule

// File: tb/tb_pic_control_unit.sv
// Directed bench for pic_control_unit (NUM_IRQ=8 and NUM_IRQ=4 instances).
module tb_pic_control_unit;
  import pic_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, wr_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
  logic       use4 = 1'b0;
  logic [7:0] din = 8'h00, irq_drv = 8'h00;

  logic [7:0] irq8, vec_out8, irr8, isr8, imr8;
  logic       intr8, vec_oe8, done8;
  logic [3:0] irq4, irr4, isr4, imr4;
  logic [7:0] vec_out4;
  logic       intr4, vec_oe4, done4;

  logic [7:0] vec_out_s, irr_s, isr_s, imr_s;
  logic       intr_s, vec_oe_s, done_s;

  int         checks = 0, errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign irq8 = use4 ? 8'h00 : irq_drv;
  assign irq4 = use4 ? irq_drv[3:0] : 4'h0;

  assign intr_s    = use4 ? intr4 : intr8;
  assign vec_out_s = use4 ? vec_out4 : vec_out8;
  assign vec_oe_s  = use4 ? vec_oe4 : vec_oe8;
  assign irr_s     = use4 ? {4'h0, irr4} : irr8;
  assign isr_s     = use4 ? {4'h0, isr4} : isr8;
  assign imr_s     = use4 ? {4'h0, imr4} : imr8;
  assign done_s    = use4 ? done4 : done8;

  pic_control_unit #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .rst(rst), .wr_n(wr_n), .a0(a0), .din(din), .irq(irq8),
    .inta_n(inta_n), .intr(intr8), .vec_out(vec_out8), .vec_oe(vec_oe8),
    .irr(irr8), .isr(isr8), .imr(imr8), .init_done(done8)
  );

  pic_control_unit #(.NUM_IRQ(4)) dut4 (
    .clk(clk), .rst(rst), .wr_n(wr_n), .a0(a0), .din(din), .irq(irq4),
    .inta_n(inta_n), .intr(intr4), .vec_out(vec_out4), .vec_oe(vec_oe4),
    .irr(irr4), .isr(isr4), .imr(imr4), .init_done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk); a0 = a; din = d; wr_n = 1'b0;
    @(negedge clk); wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic irq_pulse(input int b);
    @(negedge clk); irq_drv[b] = 1'b1;
    @(negedge clk); irq_drv[b] = 1'b0;
    @(negedge clk);
  endtask

  // Two INTA pulses; the vector is compared against the scoreboard head.
  task automatic do_ack(input logic [7:0] isr_mid);
    logic [7:0] exp;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk); chk("intr_drop", intr_s, 1'b0); inta_n = 1'b1;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk);
    chk("vec_oe_on", vec_oe_s, 1'b1);
    chk("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk("vec_out", vec_out_s, exp);
    end
    chk("isr_in_ack", isr_s, isr_mid);
    inta_n = 1'b1;
    @(negedge clk); chk("vec_oe_off", vec_oe_s, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    idle(3);
    chk("rst_intr", intr_s, 1'b0);
    chk("rst_vec_oe", vec_oe_s, 1'b0);
    chk("rst_vec_out", vec_out_s, 8'h00);
    chk("rst_irr", irr_s, 8'h00);
    chk("rst_isr", isr_s, 8'h00);
    chk("rst_imr", imr_s, 8'h00);
    chk("rst_done", done_s, 1'b0);
    rst = 1'b0;

    // init and ack, edge mode
    wr(1'b0, 8'h13); chk("icw2_wait", done_s, 1'b0);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h01); chk("ready", done_s, 1'b1);
    irq_pulse(3);
    chk("irr3", irr_s, 8'h08);
    chk("intr3", intr_s, 1'b1);
    sb.push_back(8'h43); do_ack(8'h08);
    chk("isr3_held", isr_s, 8'h08);
    chk("irr3_clr", irr_s, 8'h00);
    wr(1'b0, 8'h20); chk("ns_eoi", isr_s, 8'h00);

    // masking and nesting
    wr(1'b1, 8'h04); chk("imr4", imr_s, 8'h04);
    @(negedge clk); irq_drv = 8'h24;
    idle(2);
    chk("irr_25", irr_s, 8'h24);
    chk("intr_5", intr_s, 1'b1);
    sb.push_back(8'h45); do_ack(8'h20);
    chk("irr_masked", irr_s, 8'h04);
    idle(1); chk("masked_no_intr", intr_s, 1'b0);
    irq_drv = 8'h00;
    wr(1'b1, 8'h00); chk("nested_intr", intr_s, 1'b1);
    sb.push_back(8'h42); do_ack(8'h24);
    wr(1'b0, 8'h20); chk("eoi_hi_first", isr_s, 8'h20);
    wr(1'b0, 8'h20); chk("eoi_second", isr_s, 8'h00);

    // auto-EOI
    wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h03);
    chk("aeoi_ready", done_s, 1'b1);
    irq_pulse(1); chk("intr1", intr_s, 1'b1);
    sb.push_back(8'h41); do_ack(8'h02);
    chk("aeoi_clr", isr_s, 8'h00);

    // rotation: set priority lowest=3, then 2 and 4 together
    wr(1'b0, 8'hC3);
    @(negedge clk); irq_drv = 8'h14;
    idle(2);
    chk("irr_24", irr_s, 8'h14);
    sb.push_back(8'h44); do_ack(8'h10);
    idle(1); chk("intr_next", intr_s, 1'b1);
    sb.push_back(8'h42); do_ack(8'h04);
    chk("rot_isr_clr", isr_s, 8'h00);
    irq_drv = 8'h00;

    // spurious ack in level mode
    wr(1'b0, 8'h1B); wr(1'b1, 8'h40); wr(1'b1, 8'h01);
    @(negedge clk); irq_drv = 8'h40;
    idle(2);
    chk("lvl_irr", irr_s, 8'h40);
    chk("lvl_intr", intr_s, 1'b1);
    irq_drv = 8'h00;
    sb.push_back(8'h47); do_ack(8'h00);
    chk("spur_isr", isr_s, 8'h00);
    chk("lvl_irr_follow", irr_s, 8'h00);

    // reset mid-ack
    @(negedge clk); irq_drv = 8'h40;
    idle(2);
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk); inta_n = 1'b1;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_oe", vec_oe_s, 1'b1);
    chk("pre_rst_isr", isr_s, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_oe", vec_oe_s, 1'b0);
    chk("rst_mid_intr", intr_s, 1'b0);
    chk("rst_mid_isr", isr_s, 8'h00);
    chk("rst_mid_done", done_s, 1'b0);
    chk("rst_mid_state", 32'(dut8.init_q), 32'(ST_UNINIT));
    inta_n = 1'b1; irq_drv = 8'h00;
    @(negedge clk); rst = 1'b0;
    wr(1'b1, 8'h55);
    chk("uninit_ocw1_ignored", imr_s, 8'h00);
    chk("uninit_done", done_s, 1'b0);

    // NUM_IRQ=4: vector uses icw2[7:2]
    use4 = 1'b1;
    wr(1'b0, 8'h13); wr(1'b1, 8'h4C); wr(1'b1, 8'h01);
    chk("n4_ready", done_s, 1'b1);
    irq_pulse(3);
    chk("n4_irr", irr_s, 8'h08);
    chk("n4_intr", intr_s, 1'b1);
    sb.push_back(8'h4F); do_ack(8'h08);
    wr(1'b0, 8'h20); chk("n4_eoi", isr_s, 8'h00);
    irq_pulse(1);
    sb.push_back(8'h4D); do_ack(8'h02);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_control_unit.md
# pic_control_unit

Clocked, parametrised successor to the interrupt controller's control logic. It runs the ICW1–ICW4 initialisation sequence and decodes OCW1/OCW2, and it owns the IRR, ISR and IMR registers. It handles edge- or level-triggered requests with fully nested, optionally rotating priority, and sequences the two-pulse INTA handshake. It sits between the read/write logic and the data bus buffer, replacing the earlier asynchronous control block.

## Interface
- NUM_IRQ, 8: request lines; legal values are 2, 4 or 8. ID_W = clog2(NUM_IRQ).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_n  in  1  write strobe, active low, synchronous to clk.
- a0  in  1  address bit qualifying writes.
- din  in  8  write data.
- irq  in  NUM_IRQ  interrupt request lines, synchronous to clk.
- inta_n  in  1  interrupt acknowledge, active low, synchronous to clk.
- intr  out  1  interrupt request to CPU (registered).
- vec_out  out  8  vector byte.
- vec_oe  out  1  data bus buffer drive enable for vec_out.
- irr, isr, imr  out  NUM_IRQ  each  status registers.
- init_done  out  1  high in READY.

## Operation
- **Write event.** A write event fires on the cycle where the registered wr_n is 1 and the current wr_n is 0. din and a0 are sampled on that cycle.
- **ICW1** (a0=0, din[4]=1) is accepted from any state. It latches icw1, clears IMR and ISR, aborts any acknowledge, and moves the init FSM to ICW2.
- **Init FSM.** States are UNINIT, ICW2, ICW3, ICW4, READY.
  - In ICW2, an a0=1 write latches icw2. Next state is ICW3 if icw1[1]=0, else ICW4 if icw1[0]=1, else READY.
  - In ICW3, an a0=1 write is stored and has no effect. Next state is ICW4 if icw1[0]=1, else READY.
  - In ICW4, an a0=1 write latches aeoi = din[1]. Next state is READY.
  - Any a0=0 write during ICW2–ICW4 other than ICW1 is ignored.
- **OCW1** (READY, a0=1): imr <= din[NUM_IRQ-1:0].
- **OCW2** (READY, a0=0, din[4:3]=00) is selected by din[7:5]. Level L = din[ID_W-1:0].
  - 001: non-specific EOI. Clears the highest-priority set ISR bit.
  - 011: specific EOI. Clears ISR[L].
  - 101: rotating non-specific EOI. Clears as 001, and that level becomes lowest priority.
  - 111: rotating specific EOI. Clears ISR[L]; L becomes lowest.
  - 110: set priority. L becomes lowest.
  - All other codes, and OCW3 (din[4:3]=01), are ignored.
- **Trigger mode** (icw1[3]).
  - Edge mode (0): irr[i] is set on a 0→1 transition of irq[i] and held until acknowledged.
  - Level mode (1): irr[i] follows irq[i] every cycle.
- **Priority.** Order starts at (lowest+1) mod NUM_IRQ. Candidate = highest-priority bit of irr & ~imr. Pending = candidate exists and outranks every set ISR bit (fully nested).
- **intr** = pending & init_done & ack FSM in ACK_IDLE.
- **Ack FSM.** States are ACK_IDLE, ACK1, ACK2.
  - First inta_n falling edge: lock id = candidate, set ISR[id], clear IRR[id], drop intr, go to ACK1. If there is no candidate (spurious), id = NUM_IRQ-1 and ISR is unchanged.
  - Second falling edge: vec_out = {icw2[7:ID_W], id}, vec_oe = 1, go to ACK2.
  - Rising edge of inta_n in ACK2: vec_oe = 0. If aeoi is set and the ack was not spurious, clear ISR[id]. Return to ACK_IDLE.
- **Simultaneous events.**
  - EOI and ack in the same cycle: both apply; the EOI selects from ISR before the ack's set.
  - irq edge and ack clear on the same bit in the same cycle: the set wins.
  - ICW1 overrides everything.
- **Reset** (asynchronous). All outputs are 0 and all registers are 0. Init FSM = UNINIT, ack FSM = ACK_IDLE, lowest = NUM_IRQ-1.

## Timing
- Register effects of a write are visible the cycle after the write-event cycle.
- intr rises 1 cycle after the pending condition becomes true. It falls in the cycle after the first INTA edge is detected.
- vec_out and vec_oe are valid 1 cycle after the second INTA falling edge. They hold until 1 cycle after the inta_n rise.
- irr updates 1 cycle after an irq transition.
- Priority resolution is combinational from registered irr, isr, imr and lowest.

## Structure
- **Package `pic_pkg`:** init and ack state enums, OCW2 command codes, ICW bit positions (IC4, SNGL, LTIM, AEOI), and a function to check NUM_IRQ legality.
- **Sub-module `pic_priority_resolver`:** combinational rotating priority encoder. Inputs are request vector and lowest; outputs are valid and id. It is instantiated twice: once for IRR candidates and once for the ISR highest.

## Test plan
- **Init and ack, edge mode.** Write ICW1=0x13, then ICW2=0x40, then ICW4=0x01. Pulse irq[3].
  - Required: intr=1, and the two INTA pulses give vec_out=0x43.
  - Required: isr=0x08 until an OCW2 write of 0x20 clears it to 0.
- **Masking and nesting.** Write OCW1=0x04, then raise irq[2] and irq[5].
  - Required: ack gives id 5 and irq[2] never raises intr.
  - Then set OCW1=0x00 with ISR[5] still set. Required: intr rises for id 2.
- **Auto-EOI.** Write ICW4=0x03 and run one ack of irq[1]. Required: isr returns to 0 one cycle after inta_n rises.
- **Rotation.** Write OCW2=0xC3 (set priority, lowest=3), then raise irq[2] and irq[4] together. Required: id 4 is acknowledged first.
- **Spurious ack.** Assert irq[6], withdraw it in level mode, then pulse INTA twice. Required: vec_out={icw2[7:3],3'd7} and isr unchanged.
- **Reset mid-ack.** Assert rst during ACK2. Required: vec_oe, intr, isr and init_done are all 0 immediately, and the state is UNINIT.
- **Parametrisation.** Repeat the init-and-ack test with NUM_IRQ=4. Required: vector = {icw2[7:2], id}.
